// File: rtl/uart_tx_arbiter_if.sv
// Byte-source / shifter bundle for uart_tx_arbiter; gap_bits exists only with TX_GAP_EN.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
`ifdef TX_GAP_EN
    , parameter int GAP_W = 4
`endif
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   last;
    logic [8*NREQ-1:0] data;
    logic [NREQ-1:0]   ack;
    logic [OW-1:0]     owner;
    logic              active;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
`ifdef TX_GAP_EN
    logic [GAP_W-1:0]  gap_bits;
`endif

    modport master (
`ifdef TX_GAP_EN
        output gap_bits,
`endif
        output req, last, data, tx_busy,
        input  ack, owner, active, tx_start, tx_data
    );

    modport slave (
`ifdef TX_GAP_EN
        input  gap_bits,
`endif
        input  req, last, data, tx_busy,
        output ack, owner, active, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locking arbiter sharing one UART shifter; grant 1 bclk after req in IDLE,
// sources wait on ack, shifter paces via tx_busy. TX_GAP_EN adds idle bit times after each frame.
module uart_tx_arbiter #(
    parameter int NREQ     = 4,
    parameter int LOCK_TMO = 64
`ifdef TX_GAP_EN
    , parameter int GAP_W  = 4
`endif
) (
    input  logic             reset,
    input  logic             bclk,
    uart_tx_arbiter_if.slave bus
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (LOCK_TMO > 1) ? $clog2(LOCK_TMO) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        SEND  = 3'd2,
`ifdef TX_GAP_EN
        GAP   = 3'd3,
`endif
        HOLD  = 3'd4
    } state_t;

    state_t          state, state_n;
    logic [OW-1:0]   owner_q, owner_n, rr_q, rr_n, grant_src;
    logic [7:0]      txd_q, txd_n;
    logic            start_q, start_n, active_q, active_n, lock_q, lock_n;
    logic [NREQ-1:0] ack_q, ack_n;
    logic [TW-1:0]   tmr_q, tmr_n;
    logic            grant, finish;
`ifdef TX_GAP_EN
    logic [GAP_W-1:0] gap_q, gap_n;
`endif

    // Scan downward so the nearest requester after the pointer is assigned last and wins.
    function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [OW-1:0] p);
        logic [OW-1:0] w;
        int idx;
        w = p;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(p) + k) % NREQ;
            if (r[idx]) w = idx[OW-1:0];
        end
        return w;
    endfunction

    always_comb begin
        state_n   = state;
        owner_n   = owner_q;
        rr_n      = rr_q;
        txd_n     = txd_q;
        start_n   = start_q;
        ack_n     = '0;
        active_n  = active_q;
        lock_n    = lock_q;
        tmr_n     = tmr_q;
        grant     = 1'b0;
        finish    = 1'b0;
        grant_src = owner_q;
`ifdef TX_GAP_EN
        gap_n     = gap_q;
`endif
        case (state)
            IDLE: begin
                active_n = 1'b0;
                if (bus.req != '0 && !bus.tx_busy) begin
                    grant     = 1'b1;
                    grant_src = rr_pick(bus.req, rr_q);
                    rr_n      = grant_src;
                end
            end
            START: begin
                if (bus.tx_busy) begin
                    start_n = 1'b0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (!bus.tx_busy) begin
`ifdef TX_GAP_EN
                    if (bus.gap_bits != '0) begin
                        gap_n   = bus.gap_bits;
                        state_n = GAP;
                    end else begin
                        finish = 1'b1;
                    end
`else
                    finish = 1'b1;
`endif
                end
            end
`ifdef TX_GAP_EN
            GAP: begin
                if (gap_q <= GAP_W'(1)) finish = 1'b1;
                else                    gap_n  = gap_q - 1'b1;
            end
`endif
            HOLD: begin
                if (bus.req[owner_q]) begin
                    grant = 1'b1;
                end else if (tmr_q == TW'(LOCK_TMO - 1)) begin
                    lock_n   = 1'b0;
                    active_n = 1'b0;
                    state_n  = IDLE;
                end else begin
                    tmr_n = tmr_q + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Post-frame decision: a locked owner keeps the line, rr stays on it.
        if (finish) begin
            if (lock_q && bus.req[owner_q]) begin
                grant = 1'b1;
            end else if (lock_q) begin
                tmr_n   = '0;
                state_n = HOLD;
            end else begin
                active_n = 1'b0;
                state_n  = IDLE;
            end
        end

        if (grant) begin
            owner_n          = grant_src;
            txd_n            = bus.data[8*int'(grant_src) +: 8];
            start_n          = 1'b1;
            ack_n[grant_src] = 1'b1;
            active_n         = 1'b1;
            lock_n           = ~bus.last[grant_src];
            state_n          = START;
        end
    end

    always_ff @(posedge bclk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            owner_q  <= '0;
            rr_q     <= OW'(NREQ - 1);
            txd_q    <= 8'h00;
            start_q  <= 1'b0;
            ack_q    <= '0;
            active_q <= 1'b0;
            lock_q   <= 1'b0;
            tmr_q    <= '0;
`ifdef TX_GAP_EN
            gap_q    <= '0;
`endif
        end else begin
            state    <= state_n;
            owner_q  <= owner_n;
            rr_q     <= rr_n;
            txd_q    <= txd_n;
            start_q  <= start_n;
            ack_q    <= ack_n;
            active_q <= active_n;
            lock_q   <= lock_n;
            tmr_q    <= tmr_n;
`ifdef TX_GAP_EN
            gap_q    <= gap_n;
`endif
        end
    end

    assign bus.ack      = ack_q;
    assign bus.owner    = owner_q;
    assign bus.active   = active_q;
    assign bus.tx_start = start_q;
    assign bus.tx_data  = txd_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-cycle vector table, then source/shifter models for locking,
// lock timeout and inter-frame gap sequences.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int TMO  = 64;
    localparam int FR   = 3;
`ifdef TX_GAP_EN
    localparam int GAP  = 3;
`else
    localparam int GAP  = 0;
`endif

    logic reset = 1'b1;
    logic bclk  = 1'b0;
    always #5 bclk = ~bclk;

`ifdef TX_GAP_EN
    uart_tx_arbiter_if #(.NREQ(NREQ), .GAP_W(4)) bus ();
    uart_tx_arbiter #(.NREQ(NREQ), .LOCK_TMO(TMO), .GAP_W(4)) dut (.reset(reset), .bclk(bclk), .bus(bus));
`else
    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();
    uart_tx_arbiter #(.NREQ(NREQ), .LOCK_TMO(TMO)) dut (.reset(reset), .bclk(bclk), .bus(bus));
`endif

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       busy;
        logic [3:0] ack;
        logic       start;
        logic [7:0] txd;
        logic [1:0] own;
        logic       act;
    } vec_t;
    vec_t vq[$];

    task automatic add(input logic r, input logic [3:0] q, input logic b, input logic [3:0] a,
                       input logic s, input logic [7:0] d, input logic [1:0] o, input logic ac);
        vec_t v;
        v.rst = r; v.req = q; v.busy = b; v.ack = a; v.start = s; v.txd = d; v.own = o; v.act = ac;
        vq.push_back(v);
    endtask

    // Source / shifter models
    int cnt[NREQ], sent[NREQ], dly[NREQ];
    bit fin_last[NREQ];
    int gq[$], lat_q[$];

    function automatic logic [7:0] eb(input int i, input int j);
        return 8'(i * 16 + j);
    endfunction

    task automatic run_sc(input string nm, input int budget);
        int  bcnt, fall_cyc, idx;
        bit  done;
        logic [NREQ-1:0] prev_ack;
        bcnt = 0; fall_cyc = -1; done = 0; prev_ack = '0;
        gq.delete(); lat_q.delete();
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge bclk);
            if (bus.ack != '0) begin
                idx = 0;
                for (int i = 0; i < NREQ; i++) if (bus.ack[i]) idx = i;
                chk({nm, "_ack_onehot"}, $countones(bus.ack), 1);
                chk({nm, "_ack_pulse"}, prev_ack, 0);
                chk({nm, "_ack_wanted"}, cnt[idx] > 0, 1);
                chk({nm, "_owner"}, bus.owner, idx);
                chk({nm, "_tx_data"}, bus.tx_data, eb(idx, sent[idx]));
                gq.push_back(idx);
                sent[idx]++;
                if (cnt[idx] > 0) cnt[idx]--;
            end
            prev_ack = bus.ack;
            if (bcnt != 0) begin
                bcnt--;
                if (bcnt == 0) begin
                    bus.tx_busy = 1'b0;
                    fall_cyc = c;
                end
            end else if (bus.tx_start) begin
                bus.tx_busy = 1'b1;
                bcnt = FR;
                if (fall_cyc >= 0) lat_q.push_back(c - fall_cyc);
                fall_cyc = -1;
            end
            done = (bcnt == 0) && !bus.active && (c > 4);
            for (int i = 0; i < NREQ; i++) begin
                bus.req[i]          = (cnt[i] != 0) && (c >= dly[i]);
                bus.last[i]         = (cnt[i] == 1) && fin_last[i];
                bus.data[8*i +: 8]  = eb(i, sent[i]);
                if (cnt[i] != 0) done = 0;
            end
        end
        if (!done) begin
            errors++; checks++;
            $display("FAIL %s_timeout: got not-done expected done within %0d cycles", nm, budget);
        end
    endtask

    task automatic setup(input int c0, c1, c2, c3, input int d3, input bit l0);
        cnt  = '{c0, c1, c2, c3};
        sent = '{0, 0, 0, 0};
        dly  = '{0, 0, 0, d3};
        fin_last = '{l0, 1'b1, 1'b1, 1'b1};
    endtask

    initial begin
        int e1[4];
        int e2[2];
        int e3[3];
        bus.req = '0; bus.last = '0; bus.data = '0; bus.tx_busy = 1'b0;
`ifdef TX_GAP_EN
        bus.gap_bits = 4'(GAP);
`endif
        repeat (2) @(negedge bclk);

        // rst req busy | ack start txd own act
        add(1, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 0);
        add(0, 4'b1111, 0, 4'b0001, 1, 8'h41, 0, 1);
        add(0, 4'b1110, 1, 4'b0000, 0, 8'h41, 0, 1);
        add(0, 4'b1110, 0, 4'b0000, 0, 8'h41, 0, 0);
        add(0, 4'b1110, 0, 4'b0010, 1, 8'h42, 1, 1);
        add(0, 4'b1100, 1, 4'b0000, 0, 8'h42, 1, 1);
        add(0, 4'b1100, 0, 4'b0000, 0, 8'h42, 1, 0);
        add(0, 4'b1100, 0, 4'b0100, 1, 8'h43, 2, 1);
        add(0, 4'b1000, 1, 4'b0000, 0, 8'h43, 2, 1);
        add(0, 4'b1000, 0, 4'b0000, 0, 8'h43, 2, 0);
        add(0, 4'b1000, 0, 4'b1000, 1, 8'h44, 3, 1);
        add(0, 4'b0001, 1, 4'b0000, 0, 8'h44, 3, 1);
        add(0, 4'b0001, 0, 4'b0000, 0, 8'h44, 3, 0);
        add(0, 4'b0001, 0, 4'b0001, 1, 8'h41, 0, 1);
        add(0, 4'b0000, 0, 4'b0000, 1, 8'h41, 0, 1);
        add(0, 4'b0000, 1, 4'b0000, 0, 8'h41, 0, 1);
        add(0, 4'b0000, 1, 4'b0000, 0, 8'h41, 0, 1);
        add(0, 4'b0000, 0, 4'b0000, 0, 8'h41, 0, 0);
        add(0, 4'b0010, 1, 4'b0000, 0, 8'h41, 0, 0);
        add(0, 4'b0010, 0, 4'b0010, 1, 8'h42, 1, 1);
        add(0, 4'b0000, 1, 4'b0000, 0, 8'h42, 1, 1);
        add(0, 4'b0000, 0, 4'b0000, 0, 8'h42, 1, 0);

        bus.data = {8'h44, 8'h43, 8'h42, 8'h41};
        bus.last = 4'hF;
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge bclk);
            reset = vq[i].rst;
            bus.req = vq[i].req;
            bus.tx_busy = vq[i].busy;
            @(posedge bclk); #1;
            chk($sformatf("vec%0d ack/start/txd/own/act", i),
                {bus.ack, 3'b0, bus.tx_start, bus.tx_data, 2'b0, bus.owner, 3'b0, bus.active},
                {vq[i].ack, 3'b0, vq[i].start, vq[i].txd, 2'b0, vq[i].own, 3'b0, vq[i].act});
        end

        // Reset while in START with tx_start high
        @(negedge bclk); bus.req = 4'b0001; bus.tx_busy = 1'b0;
        @(posedge bclk); #1;
        chk("pre_rst_start_ack", {bus.tx_start, bus.ack}, {1'b1, 4'b0001});
        @(negedge bclk); bus.req = 4'b0000; reset = 1'b1; #1;
        chk("rst_tx_start", bus.tx_start, 0);
        chk("rst_ack", bus.ack, 0);
        chk("rst_active", bus.active, 0);
        chk("rst_tx_data", bus.tx_data, 8'h00);
        @(negedge bclk); reset = 1'b0; bus.req = 4'b0100;
        @(posedge bclk); #1;
        chk("post_rst_grant", {bus.ack, 2'b0, bus.owner, 3'b0, bus.tx_start}, {4'b0100, 2'b0, 2'd2, 3'b0, 1'b1});
        @(negedge bclk); bus.req = 4'b0000; bus.tx_busy = 1'b1;
        @(negedge bclk); bus.tx_busy = 1'b0;
        @(negedge bclk);

        // src1 3-byte message locks out src2
        setup(0, 3, 1, 0, 0, 1'b1);
        run_sc("lock", 400);
        e1 = '{1, 1, 1, 2};
        chk("lock_n_grants", gq.size(), 4);
        for (int i = 0; i < 4 && i < gq.size(); i++) chk($sformatf("lock_order%0d", i), gq[i], e1[i]);
        chk("lock_n_lat", lat_q.size(), 3);
        if (lat_q.size() == 3) begin
            chk("lock_lat_b2", lat_q[0], 1);
            chk("lock_lat_b3", lat_q[1], 1);
            chk("lock_lat_src2", lat_q[2], 2);
        end

        // src0 locks then goes quiet; src3 only after lock timeout
        setup(1, 0, 0, 1, 2, 1'b0);
        run_sc("tmo", 600);
        e2 = '{0, 3};
        chk("tmo_n_grants", gq.size(), 2);
        for (int i = 0; i < 2 && i < gq.size(); i++) chk($sformatf("tmo_order%0d", i), gq[i], e2[i]);
        chk("tmo_n_lat", lat_q.size(), 1);
        if (lat_q.size() == 1) chk("tmo_lat_src3", lat_q[0], TMO + 2);

        // src0 2-byte message then src1; gap (if built in) delays each restart by GAP
        setup(2, 1, 0, 0, 0, 1'b1);
        run_sc("gap", 400);
        e3 = '{0, 0, 1};
        chk("gap_n_grants", gq.size(), 3);
        for (int i = 0; i < 3 && i < gq.size(); i++) chk($sformatf("gap_order%0d", i), gq[i], e3[i]);
        chk("gap_n_lat", lat_q.size(), 2);
        if (lat_q.size() == 2) begin
            chk("gap_lat_locked", lat_q[0], GAP + 1);
            chk("gap_lat_unlocked", lat_q[1], GAP + 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
